// File: rtl/fetch_sequencer_if.sv
// Fetch sequencer bus bundle: instruction-memory request/response, decode
// hand-off and branch-unit redirect signals.
interface fetch_sequencer_if;
    logic        stall;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr_data;
    logic [31:0] instr_pc;
    logic        br_valid;
    logic        br_taken;
    logic [31:0] br_target;
    logic        br_misaligned;

    // The sequencer drives requests, the decode buffer and the misalign flag.
    modport master (
        input  stall, imem_req_ready, imem_rsp_valid, imem_rsp_data,
               instr_ready, br_valid, br_taken, br_target,
        output imem_req_valid, imem_req_addr, instr_valid, instr_data,
               instr_pc, br_misaligned
    );

    // Environment side: imem, decode and branch unit.
    modport slave (
        output stall, imem_req_ready, imem_rsp_valid, imem_rsp_data,
               instr_ready, br_valid, br_taken, br_target,
        input  imem_req_valid, imem_req_addr, instr_valid, instr_data,
               instr_pc, br_misaligned
    );
endinterface

// File: rtl/fetch_sequencer.sv
// Fetch sequencer: owns the PC, keeps one imem request outstanding, buffers
// the returned word for decode and applies taken-branch redirects.
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               rst_n,
    fetch_sequencer_if.master  fs
);

    typedef enum logic [1:0] {
        ST_BOOT,
        ST_REQ,
        ST_WAIT,
        ST_HOLD
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] issued_pc_q, issued_pc_d;
    logic        drop_q, drop_d;
    logic        instr_valid_q, instr_valid_d;
    logic [31:0] instr_data_q, instr_data_d;
    logic [31:0] instr_pc_q, instr_pc_d;
    logic        br_mis_q, br_mis_d;

    logic redirect;
    logic misaligned;
    logic req_valid;
    logic handshake;

    assign redirect   = fs.br_valid && fs.br_taken && (fs.br_target[1:0] == 2'b00);
    assign misaligned = fs.br_valid && fs.br_taken && (fs.br_target[1:0] != 2'b00);
    assign req_valid  = (state_q == ST_REQ) && !fs.stall;
    assign handshake  = req_valid && fs.imem_req_ready;

    assign fs.imem_req_valid = req_valid;
    assign fs.imem_req_addr  = pc_q;
    assign fs.instr_valid    = instr_valid_q;
    assign fs.instr_data     = instr_data_q;
    assign fs.instr_pc       = instr_pc_q;
    assign fs.br_misaligned  = br_mis_q;

    // Next-state logic: fetch sequencing first, redirect overrides last.
    always_comb begin
        // NOTE: every target is given its current value first so no path
        // through the case leaves a signal unassigned (that would infer a latch).
        state_d       = state_q;
        pc_d          = pc_q;
        issued_pc_d   = issued_pc_q;
        drop_d        = drop_q;
        instr_valid_d = instr_valid_q;
        instr_data_d  = instr_data_q;
        instr_pc_d    = instr_pc_q;
        br_mis_d      = misaligned;

        case (state_q)
            ST_BOOT: state_d = ST_REQ;
            ST_REQ: begin
                if (handshake) begin
                    issued_pc_d = pc_q;
                    pc_d        = pc_q + 32'd4;
                    state_d     = ST_WAIT;
                    // A redirect in the handshake cycle makes this request wrong-path.
                    if (redirect) drop_d = 1'b1;
                end
            end
            ST_WAIT: begin
                if (fs.imem_rsp_valid) begin
                    if (drop_q || redirect) begin
                        drop_d  = 1'b0;
                        state_d = ST_REQ;
                    end else begin
                        instr_data_d  = fs.imem_rsp_data;
                        instr_pc_d    = issued_pc_q;
                        instr_valid_d = 1'b1;
                        state_d       = ST_HOLD;
                    end
                end else if (redirect) begin
                    drop_d = 1'b1;
                end
            end
            ST_HOLD: begin
                if (fs.instr_ready || redirect) begin
                    instr_valid_d = 1'b0;
                    state_d       = ST_REQ;
                end
            end
            default: state_d = ST_BOOT;
        endcase

        if (redirect) begin
            pc_d          = fs.br_target;
            instr_valid_d = 1'b0;
        end
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_BOOT;
            pc_q          <= RESET_PC;
            issued_pc_q   <= 32'h0;
            drop_q        <= 1'b0;
            instr_valid_q <= 1'b0;
            instr_data_q  <= 32'h0;
            instr_pc_q    <= 32'h0;
            br_mis_q      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values regardless of statement order.
            state_q       <= state_d;
            pc_q          <= pc_d;
            issued_pc_q   <= issued_pc_d;
            drop_q        <= drop_d;
            instr_valid_q <= instr_valid_d;
            instr_data_q  <= instr_data_d;
            instr_pc_q    <= instr_pc_d;
            br_mis_q      <= br_mis_d;
        end
    end

endmodule
